// File: rtl/rs_complex_sched.sv
// Two-entry reservation station for the complex execution unit.
// Captures CDB results for pending operands and issues the oldest ready entry.
module rs_complex_sched #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [113:0]       disp_inst,
    input  logic [ROB_W-1:0]   disp_rob_num,
    input  logic [ROB_W-1:0]   disp_rs1_tag,
    input  logic [ROB_W-1:0]   disp_rs2_tag,
    input  logic               cdb_valid,
    input  logic [ROB_W-1:0]   cdb_rob_num,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic               issue_valid,
    output logic [113:0]       issue_inst,
    output logic [ROB_W-1:0]   issue_rob_num,
    input  logic               issue_ready,
    output logic [1:0]         occupancy
);
    logic [1:0]       valid;
    logic             older;
    logic [113:0]     inst [2];
    logic [ROB_W-1:0] rob  [2];
    logic [ROB_W-1:0] tag1 [2];
    logic [ROB_W-1:0] tag2 [2];

    logic [1:0]   rdy;
    logic         sel;
    logic         fire;
    logic         accept;
    logic         slot;
    logic         other_stays;
    logic [113:0] disp_word;

    assign rdy[0] = valid[0] & inst[0][5] & inst[0][38];
    assign rdy[1] = valid[1] & inst[1][5] & inst[1][38];

    // With both ready the age bit decides; otherwise the single ready entry wins.
    assign sel    = (&rdy) ? older : (rdy[1] & ~rdy[0]);
    assign fire   = issue_valid & issue_ready;
    assign accept = disp_valid & disp_ready;
    assign slot   = valid[0];
    assign other_stays = valid[~slot] & ~(fire & (sel == ~slot));

    assign disp_ready    = ~&valid;
    assign occupancy     = {1'b0, valid[0]} + {1'b0, valid[1]};
    assign issue_valid   = |rdy;
    assign issue_inst    = issue_valid ? inst[sel] : '0;
    assign issue_rob_num = issue_valid ? rob[sel] : '0;

    always_comb begin
        disp_word = disp_inst;
        if (cdb_valid && !disp_inst[5] && disp_rs1_tag == cdb_rob_num) begin
            disp_word[5]    = 1'b1;
            disp_word[37:6] = cdb_data;
        end
        if (cdb_valid && !disp_inst[38] && disp_rs2_tag == cdb_rob_num) begin
            disp_word[38]    = 1'b1;
            disp_word[70:39] = cdb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            older <= 1'b0;
        end else if (flush) begin
            valid <= '0;
            older <= 1'b0;
        end else begin
            if (fire)
                valid[sel] <= 1'b0;
            if (accept)
                valid[slot] <= 1'b1;
            if (accept)
                older <= other_stays ? ~slot : slot;
            else if (fire && valid[~sel])
                older <= ~sel;
        end
    end

    // Payload storage carries no reset; it is only observed through valid.
    for (genvar g = 0; g < 2; g++) begin : g_entry
        always_ff @(posedge clk) begin
            if (accept && slot == 1'(g)) begin
                inst[g] <= disp_word;
                rob[g]  <= disp_rob_num;
                tag1[g] <= disp_rs1_tag;
                tag2[g] <= disp_rs2_tag;
            end else begin
                if (cdb_valid && valid[g] && !inst[g][5] && tag1[g] == cdb_rob_num) begin
                    inst[g][5]    <= 1'b1;
                    inst[g][37:6] <= cdb_data;
                end
                if (cdb_valid && valid[g] && !inst[g][38] && tag2[g] == cdb_rob_num) begin
                    inst[g][38]    <= 1'b1;
                    inst[g][70:39] <= cdb_data;
                end
            end
        end
    end
endmodule

// File: doc/rs_complex_sched.md
Name: rs_complex_sched

Overview:
- Two-entry reservation station and issue scheduler in front of the complex execution unit.
- Accepts dispatched complex instructions and captures missing operands from the common data bus (CDB).
- Tracks age and issues the oldest ready entry to the execution unit over a valid/ready handshake.
- Clears all entries on pipeline flush.

Parameters:
ROB_W, 4, width of ROB entry number and of source tags
DATA_W, 32, operand / CDB data width (the payload layout below is fixed for DATA_W=32)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of all entries
disp_valid  input  1  dispatch request
disp_ready  output  1  at least one free entry
disp_inst  input  114  payload: [4:0] wrAddr, [5] rs1 rdy, [37:6] rs1 val, [38] rs2 rdy, [70:39] rs2 val, [71] regwrite, [72] branch, [73] memtoreg, [74] memread, [75] memwrite, [81:76] aluop, [113:82] memdata
disp_rob_num  input  ROB_W  ROB entry of dispatched instruction
disp_rs1_tag  input  ROB_W  producer ROB number for rs1 (meaningful only when rs1 rdy=0)
disp_rs2_tag  input  ROB_W  producer ROB number for rs2 (meaningful only when rs2 rdy=0)
cdb_valid  input  1  result broadcast valid
cdb_rob_num  input  ROB_W  ROB number of broadcast result
cdb_data  input  DATA_W  broadcast value
issue_valid  output  1  an entry with both operands ready is presented
issue_inst  output  114  payload of selected entry
issue_rob_num  output  ROB_W  ROB number of selected entry
issue_ready  input  1  execution unit accepts this cycle
occupancy  output  2  number of valid entries, 0..2

Behaviour:
- Reset (async, rst=1): both entry valid bits = 0 and age bit = 0. Outputs: disp_ready=1, issue_valid=0, issue_inst=0, issue_rob_num=0, occupancy=0.
- Entry state: valid, 114-bit payload, rob_num, rs1_tag, rs2_tag. Age bit `older` (0 or 1) names the older entry when both are valid.
- disp_ready = (occupancy < 2), computed from current state only. A slot freed by issue in the same cycle is not reusable until the next cycle.
- Dispatch accepted when disp_valid & disp_ready:
  - Writes the lowest-index free entry.
  - If the other entry is valid, that other entry becomes `older`. Otherwise `older` points to the new entry.
- Wakeup: when cdb_valid and a valid entry's rsN rdy=0 with rsN_tag==cdb_rob_num, the next edge sets rsN rdy=1 and rsN val=cdb_data.
  - Applies to both sources and both entries independently.
- Dispatch bypass: if the instruction being dispatched has rsN rdy=0 and disp_rsN_tag==cdb_rob_num with cdb_valid in the same cycle, it is stored already ready with cdb_data.
- Selection (combinational from stored state): an entry is ready when valid & rs1 rdy & rs2 rdy.
  - Both ready: select `older`.
  - One ready: select it.
  - None ready: issue_valid=0 and issue_inst/issue_rob_num=0.
- Issue: when issue_valid & issue_ready, the selected entry's valid bit clears at the edge. If the other entry remains valid, it becomes `older`.
- Latency:
  - A dispatched entry with both operands ready (including via bypass) asserts issue_valid the cycle after dispatch.
  - An entry woken by the CDB asserts issue_valid the cycle after the broadcast.
  - There is no same-cycle pass-through.
- Stall: while issue_ready=0, the selection and outputs hold stable. Exception: a newly ready older entry may replace a younger selected one.
- Simultaneous dispatch, issue and wakeup in one cycle are all honoured. Occupancy updates by +1, -1, or 0 accordingly.
- flush=1: all valid bits clear at the edge and `older`=0. Flush takes priority over any dispatch in the same cycle.
- Reset asserted mid-operation clears state immediately, independent of clk.

Test Plan:
- Reset, then dispatch rob 3 with rs1/rs2 rdy=1, aluop=6'h05, issue_ready=1 -> next cycle issue_valid=1, issue_rob_num=3, issue_inst matches; the cycle after, occupancy=0.
- Dispatch rob 1 with rs1 rdy=0, tag=7 -> issue_valid stays 0. Drive cdb_valid=1, cdb_rob_num=7, cdb_data=32'hDEADBEEF -> next cycle issue_valid=1 and issue_inst[37:6]=32'hDEADBEEF.
- Dispatch rob 2 (tag 5 pending), then rob 4 (ready); hold issue_ready=0 -> disp_ready=0, occupancy=2, rob 4 presented. Broadcast tag 5 -> rob 2 (older) presented; raise issue_ready -> rob 2 issues, then rob 4.
- Dispatch with rs2 rdy=0, tag=9 in the same cycle as a CDB broadcast of rob 9 with value 32'h12345678 -> issues the next cycle with [70:39]=32'h12345678.
- With occupancy=2, assert flush together with disp_valid -> next cycle occupancy=0, disp_ready=1, issue_valid=0.
- Assert rst asynchronously mid-cycle with 2 entries valid -> issue_valid and occupancy drop to 0 before the next clk edge.
